conv_result_writer: RTL and testbench
=====================================

// Module: conv_result_writer
// PURPOSE
//  Write-back end of the conv datapath. The conv controller reads weights and pixels into ConvAccum;
//  this block takes the finished output pixels and writes them to memory, row-major, from a per-instruction base.
//  Single clock domain (Clk0 of the conv controller). Sits between the ConvAccum result stream and the memory write port.
//  It has a 4-entry skid FIFO so a stalled write port backpressures the producer without losing data.
// PARAMETERS
//  DataWidth     32  width of one output pixel / memory word
//  MaxAddrWidth  32  memory address width
//  MaxPictWidth   9  width of input picture side length
//  MaxPixelNum   18  width of output pixel index / row accumulator
//  FifoDepth      4  skid FIFO entries (power of 2)
// PORTS
//  Clk              in   1             clock
//  Rst              in   1             async reset, active-high
//  out_addr_in      in   MaxAddrWidth  base write address of current instruction
//  pict_size_in     in   MaxPictWidth  input picture side N; output side O = N-2 (3x3 kernel)
//  inst_tag_in      in   1             toggles when a new instruction is issued
//  pix_data_in      in   DataWidth     output pixel from accumulator
//  pix_valid_in     in   1             pix_data_in valid
//  pix_ready_out    out  1             block accepts pixel this cycle (valid&ready = transfer)
//  write_addr_out   out  MaxAddrWidth  memory write address
//  write_data_out   out  DataWidth     memory write data
//  write_en_out     out  1             write request; held with addr/data stable until write_ready_in
//  write_ready_in   in   1             memory accepts write this cycle
//  done_out         out  1             all O*O pixels of the instruction written
// BEHAVIOUR
//  Reset (async, Rst=1): state=IDLE; FIFO empty; all counters 0; tag_q=0; pending=0.
//   Outputs: pix_ready_out=0, write_en_out=0, write_addr_out=0, write_data_out=0, done_out=0.
//  Instruction change: tag_q<=inst_tag_in every cycle; inst_changed = tag_q ^ inst_tag_in.
//  FSM (2-bit): IDLE=00, RUN=01, DRAIN=10, DONE=11.
//   IDLE/DONE & (inst_changed | pending): latch base=out_addr_in and O=pict_size_in-2; clear counters
//    and pending; done_out<=0. Go to RUN, or straight to DONE if pict_size_in<3 (O<=0, no writes).
//   RUN: when accepted count reaches O*O (last pixel transfer), go to DRAIN.
//   DRAIN: when FIFO empty and the last write handshake completes (write_en_out & write_ready_in,
//    write index = O*O-1), go to DONE; done_out<=1, held until the next instruction starts.
//   inst_changed while in RUN/DRAIN: sets pending=1. It does not abort the instruction.
//    It is serviced on the first DONE cycle, so done_out is high for exactly 1 cycle there.
//  Input handshake: pix_ready_out = (state==RUN) & (fifo_count<FifoDepth). It does not depend on
//   a same-cycle pop. Pixels offered outside RUN are ignored.
//  Output stage: registered. It is loaded from the FIFO head when FIFO is non-empty and
//   (!write_en_out | write_ready_in), giving back-to-back writes at 1/cycle.
//   Latency: pixel accepted at edge k reaches write_en_out=1 at the earliest after edge k+1.
//   While write_en_out=1 & !write_ready_in, write_addr_out/write_data_out are held stable.
//   A write completes without a reload: write_en_out<=0.
//  Address generation: col counter 0..O-1 and row_accum (+=O when col wraps).
//   write_addr_out = base + row_accum + col. Operands are zero-extended to MaxAddrWidth; the sum
//   wraps modulo 2^MaxAddrWidth. Counters advance only on a completed write handshake.
//  FIFO: circular, pointer wrap at FifoDepth. Simultaneous push & pop when full cannot occur (ready=0).
//   Simultaneous push & pop at any other count keeps the count unchanged.
//  Reset mid-instruction: everything is discarded immediately (async); the block returns to IDLE.
//   A tag toggle is needed to start again.
// TESTING
//  T1 N=5, base=0x100, pixels 1..9 streamed, write_ready=1 -> 9 writes addr 0x100..0x108, data 1..9,
//     in order; done_out=1 one cycle after the last write.
//  T2 same as T1 with write_ready_in low for 6 cycles from the 2nd write -> pix_ready_out drops after
//     the FIFO fills (4) plus the output stage; no loss or duplication; addr/data stable while stalled.
//  T3 N=2, tag toggle -> no write_en_out, done_out=1 within 2 cycles.
//  T4 tag toggles again during the T1 stream -> T1 completes all 9 writes; done_out high 1 cycle; the
//     next instruction (N=4, base=0x200) starts automatically -> 4 writes 0x200..0x203.
//  T5 Rst asserted after 3 of 9 writes -> outputs 0 in the same cycle; after a new tag toggle, N=4,
//     base=0x40 -> writes 0x40..0x43 only.
//  T6 base=0xFFFF_FFFE, N=4 -> addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1 (wrap).

Source files
------------

// File: rtl/conv_result_writer.sv
// ============================================================================
// Module  : conv_result_writer
// Brief   : Writes finished conv output pixels to memory in row-major order
//           through a 4-entry skid FIFO and a registered write stage.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv_result_writer #(
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_ADDR_WIDTH = 32,
   parameter int MAX_PICT_WIDTH = 9,
   parameter int MAX_PIXEL_NUM  = 18,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [MAX_ADDR_WIDTH-1:0] out_addr_in,
   input  logic [MAX_PICT_WIDTH-1:0] pict_size_in,
   input  logic                      inst_tag_in,
   input  logic [DATA_WIDTH-1:0]     pix_data_in,
   input  logic                      pix_valid_in,
   output logic                      pix_ready_out,
   output logic [MAX_ADDR_WIDTH-1:0] write_addr_out,
   output logic [DATA_WIDTH-1:0]     write_data_out,
   output logic                      write_en_out,
   input  logic                      write_ready_in,
   output logic                      done_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t                    state_q,     state_d;
   logic                      tag_q,       tag_d;
   logic                      pending_q,   pending_d;
   logic                      done_q,      done_d;
   logic [MAX_ADDR_WIDTH-1:0] base_q,      base_d;
   logic [MAX_PICT_WIDTH-1:0] side_q,      side_d;
   logic [MAX_PIXEL_NUM-1:0]  total_q,     total_d;
   logic [MAX_PIXEL_NUM-1:0]  acc_q,       acc_d;
   logic [MAX_PIXEL_NUM-1:0]  wr_idx_q,    wr_idx_d;
   logic [MAX_PICT_WIDTH-1:0] col_q,       col_d;
   logic [MAX_PIXEL_NUM-1:0]  row_q,       row_d;
   logic [DATA_WIDTH-1:0]     fifo_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]     fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q,    rd_ptr_d;
   logic [CNT_W-1:0]          count_q,     count_d;
   logic                      wen_q,       wen_d;
   logic [MAX_ADDR_WIDTH-1:0] waddr_q,     waddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q,     wdata_d;

   logic                      inst_changed;
   logic                      push;
   logic                      pop;
   logic                      wr_done;
   logic                      fifo_empty;
   logic [MAX_PICT_WIDTH-1:0] side_new;

   assign inst_changed   = tag_q ^ inst_tag_in;
   assign pix_ready_out  = (state_q == RUN) && (count_q < CNT_W'(FIFO_DEPTH));
   assign fifo_empty     = (count_q == '0);
   assign push           = pix_valid_in & pix_ready_out;
   assign wr_done        = wen_q & write_ready_in;
   assign pop            = !fifo_empty && (!wen_q || write_ready_in);
   assign write_en_out   = wen_q;
   assign write_addr_out = waddr_q;
   assign write_data_out = wdata_q;
   assign done_out       = done_q;

   always_comb begin
      state_d    = state_q;
      tag_d      = inst_tag_in;
      pending_d  = pending_q;
      done_d     = done_q;
      base_d     = base_q;
      side_d     = side_q;
      total_d    = total_q;
      acc_d      = acc_q;
      wr_idx_d   = wr_idx_q;
      col_d      = col_q;
      row_d      = row_q;
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wen_d      = wen_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      side_new   = pict_size_in - MAX_PICT_WIDTH'(2);

      // Address counters track the write held in (or next loaded into) the output stage
      if (wr_done) begin
         wr_idx_d = wr_idx_q + 1'b1;
         if (col_q == side_q - 1'b1) begin
            col_d = '0;
            row_d = row_q + MAX_PIXEL_NUM'(side_q);
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      if (pop) begin
         wen_d    = 1'b1;
         wdata_d  = fifo_mem_q[rd_ptr_q];
         waddr_d  = base_q + MAX_ADDR_WIDTH'(row_d) + MAX_ADDR_WIDTH'(col_d);
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else if (wr_done) begin
         wen_d = 1'b0;
      end

      if (push) begin
         fifo_mem_d[wr_ptr_q] = pix_data_in;
         wr_ptr_d             = wr_ptr_q + 1'b1;
         acc_d                = acc_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE, DONE: begin
            if (inst_changed || pending_q) begin
               base_d    = out_addr_in;
               side_d    = side_new;
               total_d   = MAX_PIXEL_NUM'(side_new) * MAX_PIXEL_NUM'(side_new);
               acc_d     = '0;
               wr_idx_d  = '0;
               col_d     = '0;
               row_d     = '0;
               pending_d = 1'b0;
               if (pict_size_in < MAX_PICT_WIDTH'(3)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  done_d  = 1'b0;
               end
            end
         end
         RUN: begin
            if (inst_changed) pending_d = 1'b1;
            if (push && (acc_q + 1'b1 == total_q)) state_d = DRAIN;
         end
         DRAIN: begin
            if (inst_changed) pending_d = 1'b1;
            if (wr_done && fifo_empty && (wr_idx_q == total_q - 1'b1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         tag_q     <= 1'b0;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         base_q    <= '0;
         side_q    <= '0;
         total_q   <= '0;
         acc_q     <= '0;
         wr_idx_q  <= '0;
         col_q     <= '0;
         row_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         pending_q  <= pending_d;
         done_q     <= done_d;
         base_q     <= base_d;
         side_q     <= side_d;
         total_q    <= total_d;
         acc_q      <= acc_d;
         wr_idx_q   <= wr_idx_d;
         col_q      <= col_d;
         row_q      <= row_d;
         fifo_mem_q <= fifo_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writer.sv
// ============================================================================
// Module  : tb_conv_result_writer
// Brief   : Directed self-checking bench for conv_result_writer.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_result_writer;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] out_addr_in;
   logic [8:0]  pict_size_in;
   logic        inst_tag_in;
   logic [31:0] pix_data_in;
   logic        pix_valid_in;
   logic        pix_ready_out;
   logic [31:0] write_addr_out;
   logic [31:0] write_data_out;
   logic        write_en_out;
   logic        write_ready_in;
   logic        done_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          last_wr_cyc = 0;
   int          done_cycles = 0;
   int          done_rises  = 0;
   logic        done_prev   = 1'b0;

   conv_result_writer #(
      .DATA_WIDTH(32), .MAX_ADDR_WIDTH(32), .MAX_PICT_WIDTH(9),
      .MAX_PIXEL_NUM(18), .FIFO_DEPTH(4)
   ) dut (
      .Clk(Clk), .Rst(Rst), .out_addr_in(out_addr_in), .pict_size_in(pict_size_in),
      .inst_tag_in(inst_tag_in), .pix_data_in(pix_data_in), .pix_valid_in(pix_valid_in),
      .pix_ready_out(pix_ready_out), .write_addr_out(write_addr_out),
      .write_data_out(write_data_out), .write_en_out(write_en_out),
      .write_ready_in(write_ready_in), .done_out(done_out)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc++;

   // Write/done collector, sampled mid-cycle
   always @(negedge Clk) begin
      if (write_en_out && write_ready_in) begin
         wa_q.push_back(write_addr_out);
         wd_q.push_back(write_data_out);
         last_wr_cyc = cyc;
      end
      if (done_out) done_cycles++;
      if (done_out && !done_prev) done_rises++;
      done_prev = done_out;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_inst(input logic [31:0] addr, input logic [8:0] size);
      out_addr_in  = addr;
      pict_size_in = size;
      inst_tag_in  = ~inst_tag_in;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
   endtask

   task automatic stream_pix(input int n, input logic [31:0] first, input int toggle_at,
                             input logic [31:0] nb_addr, input logic [8:0] nb_size);
      for (int i = 0; i < n; i++) begin
         logic acc;
         int   g;
         pix_data_in  = first + 32'(i);
         pix_valid_in = 1'b1;
         if (i == toggle_at) start_inst(nb_addr, nb_size);
         acc = 1'b0;
         g   = 0;
         while (!acc && g < 200) begin
            acc = pix_ready_out;
            tick();
            g++;
         end
         n_checks++;
         if (!acc) begin
            n_fail++;
            $display("FAIL stream_accept pixel %0d: not accepted within 200 cycles", i);
            break;
         end
      end
      pix_valid_in = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      int g = 0;
      while (wa_q.size() < n && g < 300) begin
         tick();
         g++;
      end
      n_checks++;
      if (wa_q.size() < n) begin
         n_fail++;
         $display("FAIL wait_writes: got %0d writes, required %0d", wa_q.size(), n);
      end
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done_out && g < 100) begin
         tick();
         g++;
      end
      n_checks++;
      if (done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_done: done_out=%b after 100 cycles, required 1", done_out);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1; inst_tag_in = 1'b0; out_addr_in = '0; pict_size_in = '0;
      pix_data_in = '0; pix_valid_in = 1'b0; write_ready_in = 1'b1;
      tick(); tick();
      n_checks += 5;
      if (pix_ready_out !== 1'b0)   begin n_fail++; $display("FAIL reset_ready: got %b, required 0", pix_ready_out); end
      if (write_en_out !== 1'b0)    begin n_fail++; $display("FAIL reset_wen: got %b, required 0", write_en_out); end
      if (write_addr_out !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", write_addr_out); end
      if (write_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", write_data_out); end
      if (done_out !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b, required 0", done_out); end
      Rst = 1'b0;
      clear_log();
      // Pixels offered in IDLE must be ignored
      pix_valid_in = 1'b1; pix_data_in = 32'hDEAD;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (pix_ready_out !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b, required 0", pix_ready_out); end
      end
      pix_valid_in = 1'b0;
      n_checks++;
      if (wa_q.size() != 0) begin n_fail++; $display("FAIL idle_writes: got %0d, required 0", wa_q.size()); end
   endtask

   task automatic test_small_picture();
      clear_log();
      n_checks++;
      if (done_out !== 1'b0) begin n_fail++; $display("FAIL t3_done_before: got %b, required 0", done_out); end
      start_inst(32'h0, 9'd2);
      tick();
      n_checks++;
      if (done_out !== 1'b1) begin n_fail++; $display("FAIL t3_done: got %b, required 1", done_out); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (write_en_out !== 1'b0) begin n_fail++; $display("FAIL t3_wen: got %b, required 0", write_en_out); end
      end
      n_checks++;
      if (wa_q.size() != 0) begin n_fail++; $display("FAIL t3_writes: got %0d, required 0", wa_q.size()); end
   endtask

   task automatic test_basic();
      clear_log();
      start_inst(32'h100, 9'd5);
      stream_pix(9, 32'd1, -1, 32'h0, 9'd0);
      wait_writes(9);
      wait_done();
      n_checks++;
      if (cyc - last_wr_cyc != 1) begin n_fail++; $display("FAIL t1_done_latency: got %0d cycles, required 1", cyc - last_wr_cyc); end
      tick(); tick();
      n_checks++;
      if (wa_q.size() != 9) begin n_fail++; $display("FAIL t1_count: got %0d, required 9", wa_q.size()); end
      for (int i = 0; i < 9 && i < wa_q.size(); i++) begin
         n_checks += 2;
         if (wa_q[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL t1_addr[%0d]: got %h, required %h", i, wa_q[i], 32'h100 + 32'(i)); end
         if (wd_q[i] !== 32'(i + 1))       begin n_fail++; $display("FAIL t1_data[%0d]: got %h, required %h", i, wd_q[i], 32'(i + 1)); end
      end
   endtask

   task automatic test_backpressure();
      logic saw_not_ready = 1'b0;
      clear_log();
      start_inst(32'h100, 9'd5);
      fork
         stream_pix(9, 32'd1, -1, 32'h0, 9'd0);
         begin
            int g = 0;
            while (wa_q.size() < 1 && g < 200) begin tick(); g++; end
            write_ready_in = 1'b0;
            for (int k = 0; k < 6; k++) begin
               tick();
               n_checks += 3;
               if (write_en_out !== 1'b1)      begin n_fail++; $display("FAIL t2_stall_wen[%0d]: got %b, required 1", k, write_en_out); end
               if (write_addr_out !== 32'h101) begin n_fail++; $display("FAIL t2_stall_addr[%0d]: got %h, required 101", k, write_addr_out); end
               if (write_data_out !== 32'h2)   begin n_fail++; $display("FAIL t2_stall_data[%0d]: got %h, required 2", k, write_data_out); end
               if (!pix_ready_out) saw_not_ready = 1'b1;
            end
            write_ready_in = 1'b1;
         end
      join
      n_checks++;
      if (saw_not_ready !== 1'b1) begin n_fail++; $display("FAIL t2_backpressure: pix_ready_out never dropped, required a drop"); end
      wait_writes(9);
      wait_done();
      tick(); tick();
      n_checks++;
      if (wa_q.size() != 9) begin n_fail++; $display("FAIL t2_count: got %0d, required 9", wa_q.size()); end
      for (int i = 0; i < 9 && i < wa_q.size(); i++) begin
         n_checks += 2;
         if (wa_q[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL t2_addr[%0d]: got %h, required %h", i, wa_q[i], 32'h100 + 32'(i)); end
         if (wd_q[i] !== 32'(i + 1))       begin n_fail++; $display("FAIL t2_data[%0d]: got %h, required %h", i, wd_q[i], 32'(i + 1)); end
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      start_inst(32'h100, 9'd5);
      tick();
      done_cycles = 0;
      done_rises  = 0;
      stream_pix(9, 32'h11, 3, 32'h200, 9'd4);
      stream_pix(4, 32'h21, -1, 32'h0, 9'd0);
      wait_writes(13);
      wait_done();
      tick();
      n_checks += 3;
      if (wa_q.size() != 13) begin n_fail++; $display("FAIL t4_count: got %0d, required 13", wa_q.size()); end
      if (done_rises != 2)   begin n_fail++; $display("FAIL t4_done_rises: got %0d, required 2", done_rises); end
      if (done_cycles != 2)  begin n_fail++; $display("FAIL t4_done_cycles: got %0d, required 2", done_cycles); end
      for (int i = 0; i < 13 && i < wa_q.size(); i++) begin
         logic [31:0] ea;
         logic [31:0] ed;
         ea = (i < 9) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 9);
         ed = (i < 9) ? 32'h11 + 32'(i)  : 32'h21 + 32'(i - 9);
         n_checks += 2;
         if (wa_q[i] !== ea) begin n_fail++; $display("FAIL t4_addr[%0d]: got %h, required %h", i, wa_q[i], ea); end
         if (wd_q[i] !== ed) begin n_fail++; $display("FAIL t4_data[%0d]: got %h, required %h", i, wd_q[i], ed); end
      end
   endtask

   task automatic test_mid_reset();
      clear_log();
      start_inst(32'h300, 9'd5);
      stream_pix(5, 32'h51, -1, 32'h0, 9'd0);
      wait_writes(3);
      Rst = 1'b1;
      #1;
      n_checks += 4;
      if (write_en_out !== 1'b0)    begin n_fail++; $display("FAIL t5_wen: got %b, required 0", write_en_out); end
      if (write_addr_out !== 32'h0) begin n_fail++; $display("FAIL t5_addr: got %h, required 0", write_addr_out); end
      if (write_data_out !== 32'h0) begin n_fail++; $display("FAIL t5_data: got %h, required 0", write_data_out); end
      if (pix_ready_out !== 1'b0)   begin n_fail++; $display("FAIL t5_ready: got %b, required 0", pix_ready_out); end
      inst_tag_in = 1'b0;
      tick(); tick();
      Rst = 1'b0;
      clear_log();
      for (int k = 0; k < 3; k++) tick();
      n_checks += 2;
      if (wa_q.size() != 0)  begin n_fail++; $display("FAIL t5_idle_writes: got %0d, required 0", wa_q.size()); end
      if (done_out !== 1'b0) begin n_fail++; $display("FAIL t5_idle_done: got %b, required 0", done_out); end
      start_inst(32'h40, 9'd4);
      stream_pix(4, 32'h61, -1, 32'h0, 9'd0);
      wait_writes(4);
      wait_done();
      tick(); tick();
      n_checks++;
      if (wa_q.size() != 4) begin n_fail++; $display("FAIL t5_count: got %0d, required 4", wa_q.size()); end
      for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
         n_checks += 2;
         if (wa_q[i] !== 32'h40 + 32'(i)) begin n_fail++; $display("FAIL t5_addr[%0d]: got %h, required %h", i, wa_q[i], 32'h40 + 32'(i)); end
         if (wd_q[i] !== 32'h61 + 32'(i)) begin n_fail++; $display("FAIL t5_data[%0d]: got %h, required %h", i, wd_q[i], 32'h61 + 32'(i)); end
      end
   endtask

   task automatic test_addr_wrap();
      logic [31:0] exp_a [4];
      exp_a[0] = 32'hFFFF_FFFE;
      exp_a[1] = 32'hFFFF_FFFF;
      exp_a[2] = 32'h0000_0000;
      exp_a[3] = 32'h0000_0001;
      clear_log();
      start_inst(32'hFFFF_FFFE, 9'd4);
      stream_pix(4, 32'h71, -1, 32'h0, 9'd0);
      wait_writes(4);
      wait_done();
      n_checks++;
      if (wa_q.size() != 4) begin n_fail++; $display("FAIL t6_count: got %0d, required 4", wa_q.size()); end
      for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
         n_checks += 2;
         if (wa_q[i] !== exp_a[i])        begin n_fail++; $display("FAIL t6_addr[%0d]: got %h, required %h", i, wa_q[i], exp_a[i]); end
         if (wd_q[i] !== 32'h71 + 32'(i)) begin n_fail++; $display("FAIL t6_data[%0d]: got %h, required %h", i, wd_q[i], 32'h71 + 32'(i)); end
      end
   endtask

   initial begin
      test_reset();
      test_small_picture();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_addr_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish within 500000 ns");
      $fatal(1);
   end

endmodule

`default_nettype wire
